// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned RESET_PC   = 0;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory read and decode hand-off signals of the fetch stage.
interface inst_fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
        input  mem_ack, mem_rdata, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
        output mem_ack, mem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_timeout.sv
// Memory-timeout watchdog: counts cycles spent waiting for mem_ack and
// raises a sticky error flag; only instantiated under FETCH_TIMEOUT_EN.
module fetch_timeout
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clock,
    input  logic clear_n,
    input  logic in_req,
    input  logic mem_ack,
    output logic fetch_err
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // Counter is zero on the first waiting cycle, so the flag rises after
    // exactly TIMEOUT_CYC unanswered cycles; it saturates and keeps waiting.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (!in_req)
                cnt <= '0;
            else if (!mem_ack && cnt != CNT_W'(TIMEOUT_CYC))
                cnt <= cnt + CNT_W'(1);
            if (in_req && !mem_ack && cnt == CNT_W'(TIMEOUT_CYC - 1))
                fetch_err <= 1'b1;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues one memory read per PC, buffers the word for
// decode and steers the PC register. Optional watchdog: FETCH_TIMEOUT_EN.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 15
`endif
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] next_pc,
    inst_fetch_if.master      bus,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fetch_err
);
    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] inst_data_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              discard;
    logic              ack_in_req;
    logic              keep_word;

    assign ack_in_req = (state == S_REQ) && bus.mem_ack;
    // A returning word is dropped if a redirect arrived earlier or now.
    assign keep_word  = ack_in_req && !discard && !branch_taken;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            state <= S_ISSUE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ISSUE: if (!branch_taken) state_nxt = S_REQ;
            S_REQ:   if (bus.mem_ack) state_nxt = keep_word ? S_HOLD : S_ISSUE;
            S_HOLD:  if (branch_taken || bus.inst_ready) state_nxt = S_ISSUE;
            default: state_nxt = S_ISSUE;
        endcase
    end

    always_comb begin
        bus.mem_req    = (state == S_REQ);
        bus.inst_valid = (state == S_HOLD);
        next_pc        = pc_in;
        if (branch_taken)
            next_pc = branch_target;
        else if (keep_word)
            next_pc = pc_in + ADDR_W'(1);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            mem_addr_q  <= ADDR_W'(RESET_PC);
            inst_data_q <= '0;
            inst_pc_q   <= ADDR_W'(RESET_PC);
            discard     <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                mem_addr_q <= pc_in;
            if (ack_in_req) begin
                discard <= 1'b0;
                if (keep_word) begin
                    inst_data_q <= bus.mem_rdata;
                    inst_pc_q   <= mem_addr_q;
                end
            end else if (state == S_REQ && branch_taken) begin
                discard <= 1'b1;
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.inst_data = inst_data_q;
    assign bus.inst_pc   = inst_pc_q;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clock    (clock),
        .clear_n  (clear_n),
        .in_req   (state == S_REQ),
        .mem_ack  (bus.mem_ack),
        .fetch_err(fetch_err)
    );
`else
    assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed fetch/branch/reset sequences,
// accepted instructions are checked by an independent monitor.
module tb_inst_fetch;
    import fetch_pkg::*;

    logic       clock;
    logic       clear_n;
    logic [7:0] pc;
    logic [7:0] next_pc;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       fetch_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    inst_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    inst_fetch #(
        .ADDR_W(8),
        .DATA_W(16)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(15)
`endif
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .pc_in        (pc),
        .next_pc      (next_pc),
        .bus          (bus),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_err    (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program counter register the fetch stage steers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) pc <= 8'h00;
        else          pc <= next_pc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted instruction must match the oldest expectation.
    always @(negedge clock) begin
        if (clear_n && bus.inst_valid && bus.inst_ready && !branch_taken) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got inst_pc=%0h inst_data=%0h expected no instruction",
                         bus.inst_pc, bus.inst_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb inst_pc", bus.inst_pc, e.pc);
                chk("sb inst_data", bus.inst_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({name, " req"}, bus.mem_req, 1);
    endtask

    // Waits for the request, acks after 'delay' cycles (>=1) with 'data'.
    task automatic do_fetch(input string name, input logic [7:0] addr,
                            input logic [15:0] data, input int delay, input bit push);
        logic [7:0] nx;
        nx = addr + 8'd1;
        wait_req(name);
        chk({name, " addr"}, bus.mem_addr, addr);
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i < delay - 1) begin
                @(negedge clock);
                chk({name, " req held"}, {bus.mem_req, bus.mem_addr}, {1'b1, addr});
            end
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        @(negedge clock);
        chk({name, " next_pc"}, next_pc, nx);
        if (push) sb.push_back('{pc: addr, data: data});
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        clear_n       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.inst_ready = 1'b1;

        repeat (2) @(negedge clock);
        chk("reset outputs", {bus.mem_req, bus.inst_valid, fetch_err, bus.mem_addr, bus.inst_pc},
            {3'b000, 8'h00, 8'h00});
        chk("reset inst_data", bus.inst_data, 16'h0000);
        chk("reset next_pc", next_pc, 8'h00);
        tick();
        clear_n = 1'b1;

        // Basic fetch, then sequential fetch at the incremented PC.
        do_fetch("t1", 8'h00, 16'h1234, 1, 1'b1);
        do_fetch("t1b", 8'h01, 16'h1111, 1, 1'b1);

        // Redirect while issuing: must stay in S_ISSUE and fetch the target.
        tick();
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        @(negedge clock);
        chk("issue branch next_pc", next_pc, 8'hFF);
        chk("issue branch no req", bus.mem_req, 0);
        tick();
        branch_taken = 1'b0;
        do_fetch("wrap", 8'hFF, 16'hABCD, 2, 1'b1);

        // Decode stalls for five cycles; a stray ack must not disturb the buffer.
        tick();
        bus.inst_ready = 1'b0;
        do_fetch("stall", 8'h00, 16'h5678, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall valid/req", {bus.inst_valid, bus.mem_req}, 2'b10);
            chk("stall next_pc", next_pc, 8'h01);
            chk("stall inst_data", bus.inst_data, 16'h5678);
            tick();
            bus.mem_ack   = (i == 1);
            bus.mem_rdata = 16'hFFFF;
        end
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 16'h0000;
        bus.inst_ready = 1'b1;

        // Branch in S_HOLD together with inst_ready: handshake is void.
        tick();
        bus.inst_ready = 1'b0;
        do_fetch("hold", 8'h01, 16'h9ABC, 1, 1'b0);
        @(negedge clock);
        chk("hold buffer", {bus.inst_valid, bus.inst_pc, bus.inst_data}, {1'b1, 8'h01, 16'h9ABC});
        tick();
        branch_taken   = 1'b1;
        branch_target  = 8'h10;
        bus.inst_ready = 1'b1;
        @(negedge clock);
        chk("hold branch next_pc", next_pc, 8'h10);
        tick();
        branch_taken = 1'b0;
        @(negedge clock);
        chk("hold branch cleared", {bus.inst_valid, bus.mem_req}, 2'b00);

        // Branch two cycles before the ack: the returned word is discarded.
        wait_req("disc");
        chk("disc addr", bus.mem_addr, 8'h10);
        tick();
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        @(negedge clock);
        chk("disc branch next_pc", next_pc, 8'h40);
        tick();
        branch_taken = 1'b0;
        @(negedge clock);
        chk("disc req held", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h10});
        chk("disc hold next_pc", next_pc, 8'h40);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        @(negedge clock);
        chk("disc ack next_pc", next_pc, 8'h40);
        tick();
        bus.mem_ack = 1'b0;
        @(negedge clock);
        chk("disc no valid", {bus.inst_valid, bus.mem_req}, 2'b00);
        do_fetch("target", 8'h40, 16'h4321, 2, 1'b1);

        // Branch arriving in the same cycle as the ack.
        wait_req("same");
        chk("same addr", bus.mem_addr, 8'h41);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        branch_taken  = 1'b1;
        branch_target = 8'h80;
        @(negedge clock);
        chk("same next_pc", next_pc, 8'h80);
        tick();
        bus.mem_ack  = 1'b0;
        branch_taken = 1'b0;
        @(negedge clock);
        chk("same no valid", {bus.inst_valid, bus.mem_req}, 2'b00);
        do_fetch("after same", 8'h80, 16'h0F0F, 1, 1'b1);

        // Reset during a request; stray ack after release is ignored.
        wait_req("rst");
        clear_n = 1'b0;
        #1;
        chk("rst req drop", {bus.mem_req, bus.mem_addr}, {1'b0, 8'h00});
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();
        clear_n = 1'b1;
        @(negedge clock);
        chk("rst stray ack next_pc", next_pc, 8'h00);
        chk("rst stray ack no req", {bus.mem_req, bus.inst_valid}, 2'b00);
        tick();
        bus.mem_ack = 1'b0;
        do_fetch("post rst", 8'h00, 16'h2222, 1, 1'b1);

`ifdef FETCH_TIMEOUT_EN
        // Timeout: flag rises after 15 unanswered cycles and is sticky.
        wait_req("to");
        chk("to err early", fetch_err, 0);
        repeat (14) @(negedge clock);
        chk("to err at 15", fetch_err, 0);
        @(negedge clock);
        chk("to err at 16", fetch_err, 1);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h3333;
        sb.push_back('{pc: 8'h01, data: 16'h3333});
        tick();
        bus.mem_ack = 1'b0;
        @(negedge clock);
        chk("to err sticky", fetch_err, 1);
        clear_n = 1'b0;
        #1;
        chk("to err cleared", fetch_err, 0);
        tick();
        clear_n = 1'b1;
`else
        chk("no timeout err", fetch_err, 0);
`endif

        repeat (3) tick();
        chk("sb drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
